pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage RV32I core. It sits beside the ID stage decoder.
//   Detects load-use hazards on the registers read in ID, and flushes IF/ID and ID/EX on jumps
//   and taken branches resolved in EX. Freezes the whole pipe while the MEM-stage bus access waits
//   for acknowledge, with a timeout error trap. Also keeps a saturating stall-cycle counter.
// PARAMETERS
//   TIMEOUT      256  max cycles in MEM_WAIT before trapping to ERROR (>=2)
//   STALL_CNT_W  32   width of stall_cycles performance counter
// PORTS
//   clk            in   1   core clock, rising edge
//   rst_n          in   1   asynchronous, active-low reset
//   id_rs1         in   5   rs1 address driven to the register file by ID
//   id_rs2         in   5   rs2 address driven to the register file by ID
//   id_uses_rs1    in   1   instruction in ID reads rs1 (0 for lui/auipc/jal)
//   id_uses_rs2    in   1   instruction in ID reads rs2 (R, S, B types only)
//   ex_mem_read    in   1   instruction in EX is a load
//   ex_rd          in   5   destination register of the instruction in EX
//   ex_jump_flag   in   1   EX resolved jal/jalr/taken branch this cycle
//   mem_req        in   1   MEM stage issues a data-bus read/write this cycle
//   mem_ack        in   1   data bus completes the access this cycle
//   err_clear      in   1   one-cycle pulse: leave ERROR state
//   pc_stall       out  1   hold PC
//   if2id_stall    out  1   hold IF/ID register
//   id2ex_stall    out  1   hold ID/EX register
//   ex2mem_stall   out  1   hold EX/MEM register
//   if2id_flush    out  1   load NOP into IF/ID
//   id2ex_flush    out  1   load NOP (bubble) into ID/EX
//   mem2wb_flush   out  1   load bubble into MEM/WB (reg_write_enable=0)
//   mem_err        out  1   sticky bus-timeout flag
//   stall_cycles   out  STALL_CNT_W  cycles in which pc_stall was 1, saturating
// BEHAVIOUR
//   Reset (rst_n=0, async): state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0. Stall/flush outputs are
//     combinational and are 0 whenever all request inputs are 0.
//   FSM states: RUN, MEM_WAIT, ERROR. Transitions happen on the rising clk edge.
//     RUN:      mem_req & !mem_ack -> MEM_WAIT, wait_cnt<=1; otherwise stay.
//     MEM_WAIT: mem_ack -> RUN, wait_cnt<=0; else if wait_cnt==TIMEOUT-1 -> ERROR, mem_err<=1;
//               else wait_cnt<=wait_cnt+1.
//     ERROR:    err_clear -> RUN, mem_err<=0, wait_cnt<=0; otherwise stay. mem_ack is ignored here.
//   mem_busy = (RUN & mem_req & !mem_ack) | MEM_WAIT | ERROR.
//   Zero-wait access (mem_req & mem_ack in the same cycle) causes no stall.
//   Priority 1 - mem_busy: pc/if2id/id2ex/ex2mem_stall=1 and mem2wb_flush=1. if2id_flush and
//     id2ex_flush are forced to 0. Jump and load-use are ignored this cycle; they re-evaluate once
//     the freeze lifts, because EX is held.
//   Priority 2 - ex_jump_flag: if2id_flush=1 and id2ex_flush=1. The PC is not stalled; it takes
//     the jump target. Load-use is ignored because the ID instruction is squashed.
//   Priority 3 - load-use: ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) |
//     (id_uses_rs2 & id_rs2==ex_rd)) gives pc_stall=1, if2id_stall=1 and id2ex_flush=1.
//     Exactly one bubble is inserted; the hazard clears on the next cycle as the load moves on.
//   x0 never creates a hazard. An id_uses_rsN=0 operand never matches.
//   stall_cycles increments each cycle pc_stall=1 and holds at all-ones, with no wrap.
//   Reset mid-MEM_WAIT aborts the wait at once. The returning mem_ack is then ignored in RUN
//   unless mem_req is high.
// TESTING
//   1 lw x5 in EX (ex_mem_read=1, ex_rd=5), add x6,x5,x1 in ID -> pc_stall=if2id_stall=id2ex_flush=1 for 1 cycle, stall_cycles=1
//   2 Same, but ex_rd=0 or id_uses_rs2=0 with rs2 match only -> all stall/flush outputs 0
//   3 ex_jump_flag=1 together with a load-use match -> if2id_flush=id2ex_flush=1, pc_stall=0
//   4 mem_req=1, mem_ack rises after 3 cycles -> 3 cycles of full freeze plus mem2wb_flush, state back to RUN, stall_cycles=3
//   5 mem_req=1, no ack, TIMEOUT=8 -> ERROR after 8 stalled cycles, mem_err=1 sticky; err_clear pulse -> RUN, mem_err=0
//   6 rst_n low in MEM_WAIT, and stall_cycles forced near max -> state=RUN/err=0/count=0 asynchronously; saturation holds at 2^W-1

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipe: load-use interlock, EX-resolved jump squash,
// MEM bus-wait freeze with timeout trap, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT     = 256,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_jump_flag,
    input  logic                   mem_req,
    input  logic                   mem_ack,
    input  logic                   err_clear,
    output logic                   pc_stall,
    output logic                   if2id_stall,
    output logic                   id2ex_stall,
    output logic                   ex2mem_stall,
    output logic                   if2id_flush,
    output logic                   id2ex_flush,
    output logic                   mem2wb_flush,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    state_t                 state_reg, state_next;
    logic [WAIT_W-1:0]      wait_cnt_reg, wait_cnt_next;
    logic                   mem_err_reg, mem_err_next;
    logic [STALL_CNT_W-1:0] stall_cycles_reg, stall_cycles_next;

    logic [4:0] id_rs   [2];
    logic [1:0] id_uses;
    logic [1:0] rs_match;
    logic       load_use;
    logic       mem_busy;

    assign id_rs[0]   = id_rs1;
    assign id_rs[1]   = id_rs2;
    assign id_uses[0] = id_uses_rs1;
    assign id_uses[1] = id_uses_rs2;

    // An operand the ID instruction does not read can never cause an interlock.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign rs_match[gi] = id_uses[gi] && (id_rs[gi] == ex_rd);
        end
    endgenerate

    assign load_use = ex_mem_read && (ex_rd != 5'd0) && (|rs_match);

    assign mem_busy = ((state_reg == ST_RUN) && mem_req && !mem_ack) ||
                      (state_reg == ST_MEM_WAIT) || (state_reg == ST_ERROR);

    always_comb begin
        pc_stall     = 1'b0;
        if2id_stall  = 1'b0;
        id2ex_stall  = 1'b0;
        ex2mem_stall = 1'b0;
        if2id_flush  = 1'b0;
        id2ex_flush  = 1'b0;
        mem2wb_flush = 1'b0;
        if (mem_busy) begin
            pc_stall     = 1'b1;
            if2id_stall  = 1'b1;
            id2ex_stall  = 1'b1;
            ex2mem_stall = 1'b1;
            mem2wb_flush = 1'b1;
        end else if (ex_jump_flag) begin
            if2id_flush = 1'b1;
            id2ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if2id_stall = 1'b1;
            id2ex_flush = 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next   = ST_ERROR;
                    mem_err_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                if (err_clear) begin
                    state_next    = ST_RUN;
                    mem_err_next  = 1'b0;
                    wait_cnt_next = '0;
                end
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Saturate at all-ones rather than wrap so long runs never read as short ones.
    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        if (pc_stall && !(&stall_cycles_reg)) begin
            stall_cycles_next = stall_cycles_reg + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_RUN;
            wait_cnt_reg     <= '0;
            mem_err_reg      <= 1'b0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg        <= state_next;
            wait_cnt_reg     <= wait_cnt_next;
            mem_err_reg      <= mem_err_next;
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    assign mem_err      = mem_err_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule
